// File: rtl/riscv_csr_unit_if.sv
// CSR access bus between the execute stage (master) and the machine-mode CSR unit (slave).
interface riscv_csr_unit_if #(
  parameter int unsigned MXLEN          = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
);
  logic [1:0]                csr_op_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i;
  logic [MXLEN-1:0]          csr_wdata_i;
  logic [MXLEN-1:0]          csr_rdata_o;
  logic                      csr_illegal_o;

  modport master (
    output csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/riscv_csr_unit.sv
// Machine-mode CSR file: trap state, interrupt enable/pending, vectored dispatch
// and wide cycle/instret counters for an RV32 core.
module riscv_csr_unit #(
  parameter int unsigned     MXLEN          = 32,
  parameter int unsigned     CSR_ADDR_WIDTH = 12,
  parameter int unsigned     CNT_WIDTH      = 64,
  parameter int unsigned     NUM_PLAT_IRQ   = 4,
  parameter logic [MXLEN-1:0] RESET_MTVEC   = 32'h0000_0000,
  localparam int unsigned    PLAT_W         = (NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  riscv_csr_unit_if.slave    csr_bus,
  input  logic               retire_i,
  input  logic               trap_i,
  input  logic [MXLEN-1:0]   trap_cause_i,
  input  logic [MXLEN-1:0]   trap_pc_i,
  input  logic               mret_i,
  input  logic               irq_ext_i,
  input  logic               irq_timer_i,
  input  logic               irq_soft_i,
  input  logic [PLAT_W-1:0]  irq_plat_i,
  output logic               irq_pending_o,
  output logic [MXLEN-1:0]   irq_cause_o,
  output logic [MXLEN-1:0]   trap_vec_o,
  output logic [MXLEN-1:0]   mepc_o
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS   = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MIE       = CSR_ADDR_WIDTH'(12'h304);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC     = CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MSCRATCH  = CSR_ADDR_WIDTH'(12'h340);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC      = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE    = CSR_ADDR_WIDTH'(12'h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MIP       = CSR_ADDR_WIDTH'(12'h344);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLE    = CSR_ADDR_WIDTH'(12'hB00);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRET  = CSR_ADDR_WIDTH'(12'hB02);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLEH   = CSR_ADDR_WIDTH'(12'hB80);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRETH = CSR_ADDR_WIDTH'(12'hB82);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_CYCLE     = CSR_ADDR_WIDTH'(12'hC00);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_INSTRET   = CSR_ADDR_WIDTH'(12'hC02);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_CYCLEH    = CSR_ADDR_WIDTH'(12'hC80);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_INSTRETH  = CSR_ADDR_WIDTH'(12'hC82);

  function automatic logic [MXLEN-1:0] irq_mask();
    logic [MXLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int unsigned i = 0; i < NUM_PLAT_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [MXLEN-1:0] IRQ_MASK = irq_mask();

  logic                 mstatus_mie_q, mstatus_mie_d;
  logic                 mstatus_mpie_q, mstatus_mpie_d;
  logic [MXLEN-1:0]     mie_q, mie_d;
  logic [MXLEN-1:0]     mtvec_q, mtvec_d;
  logic [MXLEN-1:0]     mscratch_q, mscratch_d;
  logic [MXLEN-1:0]     mepc_q, mepc_d;
  logic [MXLEN-1:0]     mcause_q, mcause_d;
  logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
  logic [CNT_WIDTH-1:0] minstret_q, minstret_d;

  csr_op_e          op;
  logic [MXLEN-1:0] mip_w;
  logic [MXLEN-1:0] irq_en;
  logic [4:0]       irq_idx;
  logic [MXLEN-1:0] csr_new;
  logic [MXLEN-1:0] mtvec_base;
  logic             known, read_only, csr_we, trap_reg_sel;

  assign op = csr_op_e'(csr_bus.csr_op_i);

  always_comb begin
    mip_w     = '0;
    mip_w[3]  = irq_soft_i;
    mip_w[7]  = irq_timer_i;
    mip_w[11] = irq_ext_i;
    for (int unsigned i = 0; i < NUM_PLAT_IRQ; i++) mip_w[16+i] = irq_plat_i[i];
  end

  // Read mux; user-level counter aliases share arms with their machine counterparts.
  always_comb begin
    csr_bus.csr_rdata_o = '0;
    known               = 1'b1;
    unique case (csr_bus.csr_addr_i)
      A_MSTATUS: begin
        csr_bus.csr_rdata_o[3] = mstatus_mie_q;
        csr_bus.csr_rdata_o[7] = mstatus_mpie_q;
      end
      A_MIE:                   csr_bus.csr_rdata_o = mie_q;
      A_MTVEC:                 csr_bus.csr_rdata_o = mtvec_q;
      A_MSCRATCH:              csr_bus.csr_rdata_o = mscratch_q;
      A_MEPC:                  csr_bus.csr_rdata_o = mepc_q;
      A_MCAUSE:                csr_bus.csr_rdata_o = mcause_q;
      A_MIP:                   csr_bus.csr_rdata_o = mip_w;
      A_MCYCLE, A_CYCLE:       csr_bus.csr_rdata_o = mcycle_q[31:0];
      A_MINSTRET, A_INSTRET:   csr_bus.csr_rdata_o = minstret_q[31:0];
      A_MCYCLEH, A_CYCLEH:     csr_bus.csr_rdata_o = MXLEN'(mcycle_q[CNT_WIDTH-1:32]);
      A_MINSTRETH, A_INSTRETH: csr_bus.csr_rdata_o = MXLEN'(minstret_q[CNT_WIDTH-1:32]);
      default:                 known = 1'b0;
    endcase
  end

  assign read_only = (csr_bus.csr_addr_i == A_CYCLE)  || (csr_bus.csr_addr_i == A_INSTRET) ||
                     (csr_bus.csr_addr_i == A_CYCLEH) || (csr_bus.csr_addr_i == A_INSTRETH);
  assign csr_bus.csr_illegal_o = !known || ((op != OP_NONE) && read_only);

  always_comb begin
    unique case (op)
      OP_WRITE: csr_new = csr_bus.csr_wdata_i;
      OP_SET:   csr_new = csr_bus.csr_rdata_o | csr_bus.csr_wdata_i;
      OP_CLEAR: csr_new = csr_bus.csr_rdata_o & ~csr_bus.csr_wdata_i;
      default:  csr_new = csr_bus.csr_rdata_o;
    endcase
  end

  assign trap_reg_sel = (csr_bus.csr_addr_i == A_MSTATUS) || (csr_bus.csr_addr_i == A_MEPC) ||
                        (csr_bus.csr_addr_i == A_MCAUSE);
  assign csr_we = (op != OP_NONE) && !csr_bus.csr_illegal_o && !(trap_i && trap_reg_sel);

  // Priority: trap entry > mret > CSR write for the trap registers; a counter
  // write replaces that cycle's increment and touches only the addressed half.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + CNT_WIDTH'(1);
    minstret_d     = retire_i ? minstret_q + CNT_WIDTH'(1) : minstret_q;

    if (csr_we) begin
      unique case (csr_bus.csr_addr_i)
        A_MSTATUS: begin
          mstatus_mie_d  = csr_new[3];
          mstatus_mpie_d = csr_new[7];
        end
        A_MIE:       mie_d      = csr_new & IRQ_MASK;
        A_MTVEC:     mtvec_d    = {csr_new[MXLEN-1:2], (csr_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
        A_MSCRATCH:  mscratch_d = csr_new;
        A_MEPC:      mepc_d     = csr_new & ~MXLEN'(3);
        A_MCAUSE:    mcause_d   = csr_new;
        A_MCYCLE:    mcycle_d   = {mcycle_q[CNT_WIDTH-1:32], csr_new};
        A_MCYCLEH:   mcycle_d   = {csr_new[HI_W-1:0], mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[CNT_WIDTH-1:32], csr_new};
        A_MINSTRETH: minstret_d = {csr_new[HI_W-1:0], minstret_q[31:0]};
        default: ;
      endcase
    end

    if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    if (trap_i) begin
      mepc_d         = trap_pc_i & ~MXLEN'(3);
      mcause_d       = trap_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign irq_en = mie_q & mip_w;

  always_comb begin
    logic plat_found;
    plat_found = 1'b0;
    irq_idx    = '0;
    if (irq_en[11])     irq_idx = 5'd11;
    else if (irq_en[3]) irq_idx = 5'd3;
    else if (irq_en[7]) irq_idx = 5'd7;
    else begin
      for (int unsigned i = 0; i < NUM_PLAT_IRQ; i++) begin
        if (!plat_found && irq_en[16+i]) begin
          irq_idx    = 5'(16 + i);
          plat_found = 1'b1;
        end
      end
    end
  end

  assign irq_pending_o = mstatus_mie_q && (|irq_en);
  assign irq_cause_o   = irq_pending_o ? {1'b1, (MXLEN-1)'(irq_idx)} : '0;

  assign mtvec_base = {mtvec_q[MXLEN-1:2], 2'b00};
  assign trap_vec_o = ((mtvec_q[1:0] == 2'b01) && trap_cause_i[MXLEN-1])
                    ? mtvec_base + {trap_cause_i[MXLEN-3:0], 2'b00}
                    : mtvec_base;

  assign mepc_o = mepc_q;

endmodule
